// File: rtl/alu_feed_pkg.sv
// Shared encodings for the alu_feed operand sequencer: ALU modes, FSM states
// and the shift-mode classifier used by both the step logic and the FSM.
package alu_feed_pkg;

    localparam logic [3:0] MODE_ADD  = 4'd0;
    localparam logic [3:0] MODE_SUB  = 4'd1;
    localparam logic [3:0] MODE_AND  = 4'd2;
    localparam logic [3:0] MODE_OR   = 4'd3;
    localparam logic [3:0] MODE_XOR  = 4'd4;
    localparam logic [3:0] MODE_SHL  = 4'd5;
    localparam logic [3:0] MODE_SHR  = 4'd6;
    localparam logic [3:0] MODE_ROL  = 4'd7;
    localparam logic [3:0] MODE_ROR  = 4'd8;
    localparam logic [3:0] MODE_ASR  = 4'd9;
    localparam logic [3:0] MODE_PASS = 4'd10;  // 10..15 all pass As

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } feed_state_e;

    // Shift/rotate modes iterate one bit per cycle.
    function automatic logic is_shift_mode(input logic [3:0] mode);
        return (mode >= MODE_SHL) && (mode <= MODE_ASR);
    endfunction

endpackage

// File: rtl/alu_feed_step.sv
// One combinational ALU step: full arithmetic/logic op, or a single-bit
// shift/rotate iteration. Overflow output exists only with ALU_FEED_OVF_EN.
module alu_feed_step
    import alu_feed_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] as_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic [3:0]       mode_i,
    output logic [WIDTH-1:0] res_o,
    output logic             cbf_o
`ifdef ALU_FEED_OVF_EN
    ,
    output logic             of_o
`endif
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, as_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
    assign diff = {1'b0, as_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, cin_i};

    // Result and carry/borrow/shift-out select by mode.
    always_comb begin
        res_o = as_i;
        cbf_o = 1'b0;
        case (mode_i)
            MODE_ADD: begin res_o = sum[WIDTH-1:0];  cbf_o = sum[WIDTH];  end
            MODE_SUB: begin res_o = diff[WIDTH-1:0]; cbf_o = diff[WIDTH]; end
            MODE_AND: res_o = as_i & b_i;
            MODE_OR:  res_o = as_i | b_i;
            MODE_XOR: res_o = as_i ^ b_i;
            MODE_SHL: begin res_o = {as_i[WIDTH-2:0], 1'b0};          cbf_o = as_i[WIDTH-1]; end
            MODE_SHR: begin res_o = {1'b0, as_i[WIDTH-1:1]};          cbf_o = as_i[0];       end
            MODE_ROL: begin res_o = {as_i[WIDTH-2:0], as_i[WIDTH-1]}; cbf_o = as_i[WIDTH-1]; end
            MODE_ROR: begin res_o = {as_i[0], as_i[WIDTH-1:1]};       cbf_o = as_i[0];       end
            MODE_ASR: begin res_o = {as_i[WIDTH-1], as_i[WIDTH-1:1]}; cbf_o = as_i[0];       end
            default:  res_o = as_i;
        endcase
    end

`ifdef ALU_FEED_OVF_EN
    // Signed overflow for add/sub; for shifts, whether this step flipped the MSB.
    always_comb begin
        of_o = 1'b0;
        if (mode_i == MODE_ADD)
            of_o = (as_i[WIDTH-1] == b_i[WIDTH-1]) && (res_o[WIDTH-1] != as_i[WIDTH-1]);
        else if (mode_i == MODE_SUB)
            of_o = (as_i[WIDTH-1] != b_i[WIDTH-1]) && (res_o[WIDTH-1] != as_i[WIDTH-1]);
        else if (is_shift_mode(mode_i))
            of_o = (res_o[WIDTH-1] != as_i[WIDTH-1]);
    end
`endif

endmodule

// File: rtl/alu_feed_seq.sv
// Operand sequencer + ALU stage feeding the accumulator. Single-step ops
// register their result at the accept edge; shift/rotate ops iterate one bit
// per cycle in SHIFT. Define ALU_FEED_OVF_EN to build the overflow (Of) logic;
// otherwise Of is tied low.
module alu_feed_seq
    import alu_feed_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] As,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [3:0]       Mode,
    input  logic [CNT_W-1:0] Count,
    output logic [WIDTH:0]   A,
    output logic             AValid,
    output logic             Of
);

    feed_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [3:0]       mode_q, mode_d;
    logic [WIDTH:0]   a_q, a_d;
    logic             avalid_q, avalid_d;

    logic [WIDTH-1:0] step_as;
    logic [3:0]       step_mode;
    logic [WIDTH-1:0] step_res;
    logic             step_cbf;

    // In SHIFT the step unit iterates on the working register; otherwise it
    // sees the live request.
    assign step_as   = (state_q == ST_SHIFT) ? work_q : As;
    assign step_mode = (state_q == ST_SHIFT) ? mode_q : Mode;

`ifdef ALU_FEED_OVF_EN
    logic step_of;
    logic ofacc_q, ofacc_d;  // sticky "MSB changed" over shift iterations
    logic of_q, of_d;
`endif

    alu_feed_step #(.WIDTH(WIDTH)) u_step (
        .as_i   (step_as),
        .b_i    (B),
        .cin_i  (Cin),
        .mode_i (step_mode),
        .res_o  (step_res),
        .cbf_o  (step_cbf)
`ifdef ALU_FEED_OVF_EN
        ,
        .of_o   (step_of)
`endif
    );

    // Next-state: accept in IDLE, iterate and retire in SHIFT.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        mode_d   = mode_q;
        a_d      = a_q;
        avalid_d = 1'b0;
`ifdef ALU_FEED_OVF_EN
        ofacc_d  = ofacc_q;
        of_d     = of_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (InValid) begin
                    if (is_shift_mode(Mode) && (Count != '0)) begin
                        work_d  = As;
                        cnt_d   = Count;
                        mode_d  = Mode;
                        state_d = ST_SHIFT;
`ifdef ALU_FEED_OVF_EN
                        ofacc_d = 1'b0;
`endif
                    end else if (is_shift_mode(Mode)) begin
                        // zero-count shift degenerates to a pass of As
                        a_d      = {As, 1'b0};
                        avalid_d = 1'b1;
`ifdef ALU_FEED_OVF_EN
                        of_d     = 1'b0;
`endif
                    end else begin
                        a_d      = {step_res, step_cbf};
                        avalid_d = 1'b1;
`ifdef ALU_FEED_OVF_EN
                        of_d     = step_of;
`endif
                    end
                end
            end
            ST_SHIFT: begin
                work_d = step_res;
                cnt_d  = cnt_q - 1'b1;
`ifdef ALU_FEED_OVF_EN
                ofacc_d = ofacc_q | step_of;
`endif
                if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    a_d      = {step_res, step_cbf};
                    avalid_d = 1'b1;
                    state_d  = ST_IDLE;
`ifdef ALU_FEED_OVF_EN
                    of_d     = ofacc_q | step_of;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset abandons any in-flight shift.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            work_q   <= '0;
            mode_q   <= '0;
            a_q      <= '0;
            avalid_q <= 1'b0;
`ifdef ALU_FEED_OVF_EN
            ofacc_q  <= 1'b0;
            of_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            mode_q   <= mode_d;
            a_q      <= a_d;
            avalid_q <= avalid_d;
`ifdef ALU_FEED_OVF_EN
            ofacc_q  <= ofacc_d;
            of_q     <= of_d;
`endif
        end
    end

    assign InReady = (state_q == ST_IDLE);
    assign A       = a_q;
    assign AValid  = avalid_q;
`ifdef ALU_FEED_OVF_EN
    assign Of      = of_q;
`else
    assign Of      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_feed_seq.sv
// Directed self-checking bench for alu_feed_seq. Expected Of values follow
// whether ALU_FEED_OVF_EN is defined for the build.
module tb_alu_feed_seq;

`ifdef ALU_FEED_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset;
    logic       InValid;
    logic       InReady;
    logic [3:0] As, B;
    logic       Cin;
    logic [3:0] Mode;
    logic [2:0] Count;
    logic [4:0] A;
    logic       AValid;
    logic       Of;

    int n_cmp = 0;
    int n_bad = 0;

    alu_feed_seq #(.WIDTH(4), .CNT_W(3)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .InValid (InValid),
        .InReady (InReady),
        .As      (As),
        .B       (B),
        .Cin     (Cin),
        .Mode    (Mode),
        .Count   (Count),
        .A       (A),
        .AValid  (AValid),
        .Of      (Of)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one rising edge and settle just after it
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic req(input logic [3:0] m, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [2:0] n);
        InValid = 1'b1;
        Mode = m; As = a; B = b; Cin = c; Count = n;
    endtask

    initial begin
        Reset = 1'b1; InValid = 1'b0;
        As = '0; B = '0; Cin = 1'b0; Mode = '0; Count = '0;
        tick(); tick();
        chk("rst_A", A, 5'b0);
        chk("rst_AValid", AValid, 1'b0);
        chk("rst_Of", Of, 1'b0);
        chk("rst_InReady", InReady, 1'b1);
        Reset = 1'b0;
        tick();

        // ADD 9+8: 17 -> res 1, carry 1, signed overflow
        req(4'd0, 4'd9, 4'd8, 1'b0, 3'd0);
        tick(); InValid = 1'b0;
        chk("add_A", A, 5'b0001_1);
        chk("add_AValid", AValid, 1'b1);
        chk("add_Of", Of, OVF);
        tick();
        chk("add_AValid_drop", AValid, 1'b0);
        chk("add_A_hold", A, 5'b0001_1);

        // SUB 3-5: -2 -> 1110, borrow
        req(4'd1, 4'd3, 4'd5, 1'b0, 3'd0);
        tick(); InValid = 1'b0;
        chk("sub_A", A, 5'b1110_1);
        chk("sub_AValid", AValid, 1'b1);
        chk("sub_Of", Of, 1'b0);

        // ADD 7+1 with Cin=0: 8 -> 1000, no carry, overflow
        req(4'd0, 4'd7, 4'd1, 1'b0, 3'd0);
        tick(); InValid = 1'b0;
        chk("add2_A", A, 5'b1000_0);
        chk("add2_Of", Of, OVF);

        // SUB 8-1 with borrow-in: 8-1-1=6 -> 0110, no borrow, overflow
        req(4'd1, 4'd8, 4'd1, 1'b1, 3'd0);
        tick(); InValid = 1'b0;
        chk("sub2_A", A, 5'b0110_0);
        chk("sub2_Of", Of, OVF);

        // SHL 1011 x3 while a competing request is held during SHIFT
        req(4'd5, 4'b1011, 4'd0, 1'b0, 3'd3);
        tick();
        req(4'd0, 4'b0101, 4'b0101, 1'b1, 3'd0);
        chk("shl_rdy0", InReady, 1'b0);
        chk("shl_vld0", AValid, 1'b0);
        tick();
        chk("shl_rdy1", InReady, 1'b0);
        chk("shl_vld1", AValid, 1'b0);
        tick();
        chk("shl_rdy2", InReady, 1'b0);
        chk("shl_vld2", AValid, 1'b0);
        InValid = 1'b0;
        tick();
        chk("shl_A", A, 5'b1000_1);
        chk("shl_AValid", AValid, 1'b1);
        chk("shl_rdy3", InReady, 1'b1);
        chk("shl_Of", Of, OVF);
        tick();
        chk("shl_AValid_once", AValid, 1'b0);

        // ROR Count=0 then same-cycle re-accept of XOR F^5
        req(4'd8, 4'b0001, 4'd0, 1'b0, 3'd0);
        tick();
        chk("ror0_A", A, 5'b0001_0);
        chk("ror0_AValid", AValid, 1'b1);
        chk("ror0_Of", Of, 1'b0);
        req(4'd4, 4'hF, 4'h5, 1'b0, 3'd0);
        tick(); InValid = 1'b0;
        chk("xor_A", A, 5'b1010_0);
        chk("xor_AValid", AValid, 1'b1);

        // ASR 1000 x2 -> 1110, last out 0, MSB never changes
        req(4'd9, 4'b1000, 4'd0, 1'b0, 3'd2);
        tick(); InValid = 1'b0;
        tick();
        chk("asr_mid_vld", AValid, 1'b0);
        tick();
        chk("asr_A", A, 5'b1110_0);
        chk("asr_AValid", AValid, 1'b1);
        chk("asr_Of", Of, 1'b0);

        // ROL 1001 x1 -> 0011, bit moved 1, MSB changed
        req(4'd7, 4'b1001, 4'd0, 1'b0, 3'd1);
        tick(); InValid = 1'b0;
        chk("rol_rdy", InReady, 1'b0);
        tick();
        chk("rol_A", A, 5'b0011_1);
        chk("rol_Of", Of, OVF);

        // SHR 0110 x2 -> 0001, last out 1
        req(4'd6, 4'b0110, 4'd0, 1'b0, 3'd2);
        tick(); InValid = 1'b0;
        tick(); tick();
        chk("shr_A", A, 5'b0001_1);

        // OR and pass modes
        req(4'd3, 4'b1010, 4'b0100, 1'b1, 3'd0);
        tick();
        chk("or_A", A, 5'b1110_0);
        req(4'd12, 4'b0110, 4'b1111, 1'b1, 3'd0);
        tick();
        chk("pass_A", A, 5'b0110_0);
        req(4'd2, 4'b1100, 4'b1010, 1'b0, 3'd0);
        tick(); InValid = 1'b0;
        chk("and_A", A, 5'b1000_0);

        // Reset one cycle into SHL x5: abandoned, no result
        req(4'd5, 4'b0111, 4'd0, 1'b0, 3'd5);
        tick(); InValid = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("rst2_A", A, 5'b0);
        chk("rst2_AValid", AValid, 1'b0);
        chk("rst2_InReady", InReady, 1'b1);
        chk("rst2_Of", Of, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rst2_no_vld", AValid, 1'b0);
        end
        chk("rst2_A_hold", A, 5'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
